// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - rebuilds a 32-bit hex value from a scanned 8-digit seven-segment bus
module seven_segment_decoder #(
    parameter int          STABLE_CYCLES = 16,
    parameter logic [31:0] TIMEOUT       = 32'd2_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic [6:0]  cat_in,
    input  logic [7:0]  an_in,
    output logic [31:0] val_out,
    output logic        valid_out,
    output logic        err_out,
    output logic        active_out
);

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

    logic [6:0]  cat_s1, cat_s2;
    logic [7:0]  an_s1, an_s2;
    logic [6:0]  seg;
    logic [7:0]  dig;
    logic [14:0] prev;
    logic [15:0] stable_cnt;
    logic        accepted;
    logic [31:0] idle_cnt;
    logic [7:0]  seen;
    logic [31:0] shadow;
    logic        frame_err;

    logic        changed;
    logic        one_hot;
    logic        accept;
    logic [3:0]  nib;
    logic        pat_ok;
    logic [7:0]  seen_n;
    logic [31:0] shadow_n;
    logic        frame_err_n;
    logic [31:0] idle_n;
    logic        frame_done;
    logic        timeout;

    assign seg = ~cat_s2;
    assign dig = ~an_s2;

    // Two-flop synchronizers; reset to all ones, which reads as a blank display
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            cat_s1 <= '1;
            cat_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            cat_s1 <= cat_in;
            cat_s2 <= cat_s1;
            an_s1  <= an_in;
            an_s2  <= an_s1;
        end
    end

    // Map an active-high segment pattern to its hex nibble
    always_comb begin
        nib    = 4'h0;
        pat_ok = 1'b1;
        case (seg)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: pat_ok = 1'b0;
        endcase
    end

    // Accept decision and merged next-state of the frame assembly
    always_comb begin
        changed     = ({dig, seg} != prev);
        one_hot     = (dig != 8'h00) && ((dig & (dig - 8'd1)) == 8'h00);
        accept      = !changed && (stable_cnt == STABLE_LAST) && !accepted && one_hot;
        seen_n      = seen;
        shadow_n    = shadow;
        frame_err_n = frame_err;
        if (accept) begin
            seen_n = seen | dig;
            if (pat_ok) begin
                for (int k = 0; k < 8; k++) begin
                    if (dig[k]) begin
                        shadow_n[4*k +: 4] = nib;
                    end
                end
            end else begin
                frame_err_n = 1'b1;
            end
        end
        if (accept) begin
            idle_n = 32'd0;
        end else if (idle_cnt == 32'hFFFF_FFFF) begin
            idle_n = idle_cnt;
        end else begin
            idle_n = idle_cnt + 32'd1;
        end
        frame_done = accept && (seen_n == 8'hFF);
        timeout    = !accept && (idle_n == TIMEOUT);
    end

    // Stability tracking: one accept per stable episode of {dig,seg}
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            prev       <= '0;
            stable_cnt <= '0;
            accepted   <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            prev     <= {dig, seg};
            idle_cnt <= idle_n;
            if (changed) begin
                stable_cnt <= '0;
                accepted   <= 1'b0;
            end else begin
                if (stable_cnt != 16'hFFFF) begin
                    stable_cnt <= stable_cnt + 16'd1;
                end
                if (accept) begin
                    accepted <= 1'b1;
                end
            end
        end
    end

    // Frame assembly, publication on completion, and discard on timeout
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            seen       <= '0;
            shadow     <= '0;
            frame_err  <= 1'b0;
            val_out    <= '0;
            valid_out  <= 1'b0;
            err_out    <= 1'b0;
            active_out <= 1'b0;
        end else begin
            valid_out <= frame_done;
            shadow    <= shadow_n;
            if (frame_done) begin
                val_out    <= shadow_n;
                err_out    <= frame_err_n;
                active_out <= 1'b1;
                seen       <= '0;
                frame_err  <= 1'b0;
            end else if (timeout) begin
                active_out <= 1'b0;
                seen       <= '0;
                frame_err  <= 1'b0;
            end else begin
                seen      <= seen_n;
                frame_err <= frame_err_n;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb/tb_seven_segment_decoder.sv - randomized self-checking bench for seven_segment_decoder
module tb_seven_segment_decoder;

    localparam int          S = 16;
    localparam logic [31:0] T = 32'd500;

    logic        clk_in;
    logic        rst_in_n;
    logic [6:0]  cat_in;
    logic [7:0]  an_in;
    logic [31:0] val_out;
    logic        valid_out;
    logic        err_out;
    logic        active_out;

    seven_segment_decoder #(.STABLE_CYCLES(S), .TIMEOUT(T)) dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .cat_in(cat_in), .an_in(an_in),
        .val_out(val_out), .valid_out(valid_out), .err_out(err_out), .active_out(active_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          m_nib [8];
    bit          m_seen [8];
    bit          m_err;
    logic [31:0] exp_val[$];
    bit          exp_err[$];
    logic [31:0] got_val[$];
    bit          got_err[$];

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (valid_out === 1'b1) begin
            got_val.push_back(val_out);
            got_err.push_back(err_out);
        end
    end

    function automatic logic [31:0] model_value();
        logic [31:0] v = 0;
        for (int k = 0; k < 8; k++) v = v + (32'(m_nib[k]) << (4 * k));
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 8; k++) begin
            m_nib[k]  = 0;
            m_seen[k] = 0;
        end
        m_err = 0;
    endfunction

    function automatic void model_accept(input int k, input logic [6:0] pat);
        int  n = -1;
        bool_all: begin end
        for (int i = 0; i < 16; i++) if (seg_tab[i] == pat) n = i;
        if (n >= 0) m_nib[k] = n;
        else m_err = 1;
        m_seen[k] = 1;
        if (m_seen.sum() with (int'(item)) == 8) begin
            exp_val.push_back(model_value());
            exp_err.push_back(m_err);
            for (int i = 0; i < 8; i++) m_seen[i] = 0;
            m_err = 0;
        end
    endfunction

    task automatic clear_queues();
        exp_val.delete(); exp_err.delete(); got_val.delete(); got_err.delete();
    endtask

    task automatic drive_digit(input int k, input logic [6:0] pat, input int hold);
        an_in  = ~(8'(1) << k);
        cat_in = ~pat;
        repeat (hold) @(negedge clk_in);
        an_in  = 8'hFF;
        cat_in = 7'h7F;
        repeat (4) @(negedge clk_in);
        if (hold >= S + 6) model_accept(k, pat);
    endtask

    task automatic scan(input logic [31:0] value, input int hold);
        for (int k = 0; k < 8; k++) drive_digit(k, seg_tab[value[4*k +: 4]], hold);
    endtask

    task automatic flush();
        an_in  = 8'hFF;
        cat_in = 7'h7F;
        repeat (int'(T) + 10) @(negedge clk_in);
        for (int k = 0; k < 8; k++) m_seen[k] = 0;
        m_err = 0;
    endtask

    task automatic test_reset();
        rst_in_n = 1'b0;
        an_in    = 8'hFF;
        cat_in   = 7'h7F;
        repeat (3) @(negedge clk_in);
        vectors++; if (val_out !== 32'h0) begin miscompares++; $display("FAIL reset_val got %h want 0", val_out); end
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid_out); end
        vectors++; if (err_out !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err_out); end
        vectors++; if (active_out !== 1'b0) begin miscompares++; $display("FAIL reset_active got %b want 0", active_out); end
        rst_in_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_full_scan();
        clear_queues();
        scan(32'hDEAD_BEEF, 100);
        vectors++;
        if (got_val.size() != 1 || exp_val.size() != 1) begin
            miscompares++; $display("FAIL full_scan_count got %0d want 1", got_val.size());
        end else begin
            vectors++; if (got_val[0] !== exp_val[0]) begin miscompares++; $display("FAIL full_scan_val got %h want %h", got_val[0], exp_val[0]); end
            vectors++; if (got_err[0] !== 1'b0) begin miscompares++; $display("FAIL full_scan_err got %b want 0", got_err[0]); end
        end
        vectors++; if (active_out !== 1'b1) begin miscompares++; $display("FAIL full_scan_active got %b want 1", active_out); end
    endtask

    task automatic test_short_hold();
        logic [31:0] v = 32'h0123_4567;
        flush();
        clear_queues();
        for (int k = 0; k < 8; k++) drive_digit(k, seg_tab[v[4*k +: 4]], (k == 3) ? S - 2 : 100);
        vectors++; if (got_val.size() != 0) begin miscompares++; $display("FAIL short_hold_no_valid got %0d want 0", got_val.size()); end
        scan(v, 100);
        vectors++;
        if (got_val.size() != 1 || exp_val.size() != 1) begin
            miscompares++; $display("FAIL short_hold_count got %0d want 1", got_val.size());
        end else begin
            vectors++; if (got_val[0] !== exp_val[0] || got_val[0] !== 32'h0123_4567) begin miscompares++; $display("FAIL short_hold_val got %h want %h", got_val[0], exp_val[0]); end
        end
    endtask

    task automatic test_bad_pattern();
        flush();
        clear_queues();
        for (int k = 0; k < 8; k++) drive_digit(k, (k == 2) ? 7'h00 : seg_tab[1], 100);
        scan(32'h1111_1111, 100);
        vectors++;
        if (got_val.size() != 2 || exp_val.size() != 2) begin
            miscompares++; $display("FAIL bad_pattern_count got %0d want 2", got_val.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (got_val[i] !== exp_val[i] || got_err[i] !== exp_err[i]) begin
                    miscompares++; $display("FAIL bad_pattern_frame%0d got %h/%b want %h/%b", i, got_val[i], got_err[i], exp_val[i], exp_err[i]);
                end
            end
            vectors++; if (got_err[0] !== 1'b1 || got_err[1] !== 1'b0) begin miscompares++; $display("FAIL bad_pattern_errs got %b%b want 10", got_err[0], got_err[1]); end
        end
    endtask

    task automatic test_ghost();
        logic [31:0] v = 32'h89AB_CDEF;
        flush();
        clear_queues();
        for (int k = 0; k < 4; k++) drive_digit(k, seg_tab[v[4*k +: 4]], 60);
        an_in  = 8'b1111_1100;
        cat_in = ~seg_tab[5];
        repeat (200) @(negedge clk_in);
        an_in  = 8'hFF;
        cat_in = 7'h7F;
        repeat (4) @(negedge clk_in);
        vectors++; if (got_val.size() != 0) begin miscompares++; $display("FAIL ghost_no_valid got %0d want 0", got_val.size()); end
        for (int k = 4; k < 8; k++) drive_digit(k, seg_tab[v[4*k +: 4]], 60);
        vectors++;
        if (got_val.size() != 1 || exp_val.size() != 1) begin
            miscompares++; $display("FAIL ghost_count got %0d want 1", got_val.size());
        end else begin
            vectors++; if (got_val[0] !== exp_val[0]) begin miscompares++; $display("FAIL ghost_val got %h want %h", got_val[0], exp_val[0]); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] v = 32'h1357_9BDF;
        int t0 = -1;
        int t1 = -1;
        flush();
        clear_queues();
        for (int k = 0; k < 7; k++) drive_digit(k, seg_tab[v[4*k +: 4]], 60);
        an_in  = ~8'h80;
        cat_in = ~seg_tab[v[31:28]];
        for (int i = 0; i < 200 && t0 < 0; i++) begin
            @(negedge clk_in);
            if (valid_out === 1'b1) t0 = cyc;
        end
        an_in  = 8'hFF;
        cat_in = 7'h7F;
        vectors++;
        if (t0 < 0) begin
            miscompares++; $display("FAIL timeout_valid_wait got none want pulse");
        end else begin
            model_accept(7, seg_tab[v[31:28]]);
            vectors++; if (active_out !== 1'b1) begin miscompares++; $display("FAIL timeout_active_high got %b want 1", active_out); end
            for (int i = 0; i < int'(T) + 50 && t1 < 0; i++) begin
                @(negedge clk_in);
                if (active_out === 1'b0) t1 = cyc;
            end
            vectors++; if (t1 - t0 != int'(T)) begin miscompares++; $display("FAIL timeout_delay got %0d want %0d", t1 - t0, T); end
            repeat (10) @(negedge clk_in);
            vectors++; if (val_out !== 32'h1357_9BDF || err_out !== 1'b0) begin miscompares++; $display("FAIL timeout_hold got %h/%b want 13579bdf/0", val_out, err_out); end
            for (int k = 0; k < 8; k++) m_seen[k] = 0;
            m_err = 0;
        end
        vectors++; if (got_val.size() != 1) begin miscompares++; $display("FAIL timeout_count got %0d want 1", got_val.size()); end
    endtask

    task automatic test_reset_mid_frame();
        flush();
        clear_queues();
        for (int k = 0; k < 5; k++) drive_digit(k, seg_tab[5], 60);
        rst_in_n = 1'b0;
        repeat (2) @(negedge clk_in);
        vectors++;
        if (val_out !== 32'h0 || valid_out !== 1'b0 || err_out !== 1'b0 || active_out !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_outputs got %h/%b/%b/%b want 0/0/0/0", val_out, valid_out, err_out, active_out);
        end
        model_reset();
        rst_in_n = 1'b1;
        @(negedge clk_in);
        scan(32'hCAFE_F00D, 100);
        vectors++;
        if (got_val.size() != 1 || exp_val.size() != 1) begin
            miscompares++; $display("FAIL mid_reset_count got %0d want 1", got_val.size());
        end else begin
            vectors++; if (got_val[0] !== exp_val[0] || got_val[0] !== 32'hCAFE_F00D || got_err[0] !== 1'b0) begin miscompares++; $display("FAIL mid_reset_val got %h/%b want %h/0", got_val[0], got_err[0], exp_val[0]); end
        end
    endtask

    task automatic test_random();
        flush();
        clear_queues();
        for (int i = 0; i < 120; i++) begin
            int         k    = $urandom_range(0, 7);
            logic [6:0] pat  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 15)];
            int         hold = ($urandom_range(0, 9) == 0) ? $urandom_range(3, S - 2) : $urandom_range(S + 6, S + 40);
            drive_digit(k, pat, hold);
        end
        vectors++;
        if (got_val.size() != exp_val.size()) begin
            miscompares++; $display("FAIL random_count got %0d want %0d", got_val.size(), exp_val.size());
        end else begin
            for (int i = 0; i < got_val.size(); i++) begin
                vectors++;
                if (got_val[i] !== exp_val[i] || got_err[i] !== exp_err[i]) begin
                    miscompares++; $display("FAIL random_frame%0d got %h/%b want %h/%b", i, got_val[i], got_err[i], exp_val[i], exp_err[i]);
                end
            end
        end
        flush();
        vectors++; if (active_out !== 1'b0) begin miscompares++; $display("FAIL random_timeout_active got %b want 0", active_out); end
    endtask

    initial begin
        rst_in_n = 1'b0;
        cat_in   = 7'h7F;
        an_in    = 8'hFF;
        test_reset();
        test_full_scan();
        test_short_hold();
        test_bad_pattern();
        test_ghost();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
